shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register, the successor of the current 4-bit behavioural/structural shift-register pair. It has a configurable width and adds arithmetic shifts plus a counted burst-shift mode with busy/done handshake. It sits under the serial I/O and datapath blocks as the common shift/rotate/load element. It is checked against the same dual-model tester scheme, so every output is fully defined every cycle.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of burst amount/counter

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- enb  in  1  clock enable; 0 freezes all state including burst counter
- dir  in  1  0 = left (toward MSB), 1 = right (toward LSB)
- s_in  in  1  serial fill bit for logical shift and burst
- mode  in  3  operation select (see Operation)
- d  in  WIDTH  parallel load data
- amt  in  CNT_W  burst length, 0..WIDTH; values >WIDTH saturate to WIDTH
- start  in  1  burst request, sampled only in IDLE with mode=BURST and enb=1
- q  out  WIDTH  register contents
- s_out  out  1  registered bit shifted/rotated out on the last shift
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- Modes, applied at each rising edge with enb=1 and state IDLE:
  - 000 SHIFT: logical shift by one; vacated bit = s_in
  - 001 ROT: rotate by one; the bit leaving re-enters at the opposite end
  - 010 LOAD: q <= d; s_out <= 0
  - 011 HOLD: q and s_out unchanged
  - 100 ASHIFT: right replicates q[WIDTH-1]; left fills 0
  - 101 BURST: q unchanged unless start=1 (see FSM)
  - 110, 111: treated as HOLD
- s_out on any shift/rotate/ashift: q[WIDTH-1] for left, q[0] for right (the pre-edge value).
- FSM with states IDLE and BURST:
  - IDLE→BURST: mode=101, start=1, enb=1, amt_sat>0; cnt <= amt_sat, busy <= 1, no shift at this edge.
  - IDLE, amt_sat=0 with start: done <= 1 for one cycle; q is unchanged; state stays IDLE.
  - BURST: each enb=1 edge performs a logical shift (dir, s_in sampled live) and decrements cnt; at the edge where cnt goes 1→0, busy <= 0, done <= 1, state → IDLE.
  - In BURST, mode, d, start and amt are ignored; enb=0 stalls without shifting.
- done is cleared on the edge after it is asserted, regardless of enb.
- enb=0 in IDLE: all outputs hold.

## Timing
- Reset (async, immediate): q=0, s_out=0, busy=0, done=0, cnt=0, state IDLE. Reset mid-burst aborts the burst and produces no done pulse.
- Single-op latency: result visible after 1 edge.
- Burst of N>0 with enb held high: busy visible after the start edge. N shifts occur on the N following edges. busy falls and done rises together after edge N+1 counted from start. Each enb=0 cycle adds one cycle.
- start held high through completion: it is re-sampled in IDLE, so a back-to-back burst begins on the edge after done is asserted.
- No combinational path from inputs to outputs.

## Structure
- Package shift_reg_pkg: mode localparams (MODE_SHIFT, MODE_ROT, MODE_LOAD, MODE_HOLD, MODE_ASHIFT, MODE_BURST) and the FSM state encoding (ST_IDLE, ST_BURST).
- One sub-module, shift_reg_next: combinational next-q/next-s_out from (q, mode, dir, s_in, d). It is shared by the IDLE and BURST paths. The burst path forces the SHIFT op.

## Test plan
- WIDTH=8. Reset, then LOAD d=8'hA5 → q=A5, s_out=0. Next edge with enb=0 → q stays A5.
- SHIFT left with s_in=1 from A5 → q=4B, s_out=1. Repeat → q=97, s_out=0.
- ROT right from 01 → q=80, s_out=1. ASHIFT right from 80 → C0, then E0. ASHIFT left from 81 → 02, s_out=1.
- BURST amt=3, dir=1, s_in=0 on q=F0 → busy=1 after start edge; q=78, 3C, 1E on next 3 edges. done=1 for exactly one cycle with busy=0. Repeat with enb=0 for 2 mid-burst cycles → completion delayed 2 cycles, q identical.
- BURST amt=0 → done pulse, busy never high, q unchanged. amt=15 → saturates to 8 shifts, q=00 with s_in=0.
- Assert reset after the 2nd burst shift → q=0, busy=0, done=0 immediately; no done pulse after release.

Source files
------------

// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_pkg
//  Description : Shared mode and FSM state encodings for shift_reg_univ.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

  // Operation select values
  localparam logic [2:0] MODE_SHIFT  = 3'b000;
  localparam logic [2:0] MODE_ROT    = 3'b001;
  localparam logic [2:0] MODE_LOAD   = 3'b010;
  localparam logic [2:0] MODE_HOLD   = 3'b011;
  localparam logic [2:0] MODE_ASHIFT = 3'b100;
  localparam logic [2:0] MODE_BURST  = 3'b101;

  // FSM state encoding
  localparam int         ST_W     = 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Direction encoding
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_reg_next.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_next
//  Description : Combinational next-state of the register contents and the
//                serial output bit for one shift/rotate/load/hold operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_next
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             s_out_i,
  input  logic [2:0]       mode_i,
  input  logic             dir_i,
  input  logic             s_in_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             s_out_o
);

  // Bit leaving the register for any single-position move (pre-edge value)
  logic w_out_bit;
  assign w_out_bit = (dir_i == DIR_RIGHT) ? q_i[0] : q_i[WIDTH-1];

  // Select the next contents; unlisted modes (BURST, 110, 111) hold
  always_comb begin
    q_o     = q_i;
    s_out_o = s_out_i;
    case (mode_i)
      MODE_SHIFT: begin
        q_o     = (dir_i == DIR_RIGHT) ? {s_in_i, q_i[WIDTH-1:1]}
                                       : {q_i[WIDTH-2:0], s_in_i};
        s_out_o = w_out_bit;
      end
      MODE_ROT: begin
        q_o     = (dir_i == DIR_RIGHT) ? {q_i[0], q_i[WIDTH-1:1]}
                                       : {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        s_out_o = w_out_bit;
      end
      MODE_LOAD: begin
        q_o     = d_i;
        s_out_o = 1'b0;
      end
      MODE_ASHIFT: begin
        // Right replicates the sign bit, left fills with zero
        q_o     = (dir_i == DIR_RIGHT) ? {q_i[WIDTH-1], q_i[WIDTH-1:1]}
                                       : {q_i[WIDTH-2:0], 1'b0};
        s_out_o = w_out_bit;
      end
      default: begin
        q_o     = q_i;
        s_out_o = s_out_i;
      end
    endcase
  end

endmodule : shift_reg_next
`default_nettype wire

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_univ
//  Description : Parametrised universal shift register with logical and
//                arithmetic shifts, rotate, parallel load and a counted burst
//                shift mode with busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enb_i,
  input  logic             dir_i,
  input  logic             s_in_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [CNT_W-1:0] amt_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] q_o,
  output logic             s_out_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] c_amt_max = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;

  logic [CNT_W-1:0] w_amt_sat;
  logic [2:0]       w_op_mode;
  logic             w_burst_req;
  logic [WIDTH-1:0] w_nxt_q;
  logic             w_nxt_sout;

  // Requests longer than the register are clamped to a full-width burst
  assign w_amt_sat   = (amt_i > c_amt_max) ? c_amt_max : amt_i;
  assign w_burst_req = (mode_i == MODE_BURST) && start_i;

  // Shared datapath: the burst path overrides the mode with a logical shift
  shift_reg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q_i     (shreg_q),
    .s_out_i (sout_q),
    .mode_i  (w_op_mode),
    .dir_i   (dir_i),
    .s_in_i  (s_in_i),
    .d_i     (d_i),
    .q_o     (w_nxt_q),
    .s_out_o (w_nxt_sout)
  );

  // State register with asynchronous clear; reset mid-burst drops the burst
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      shreg_q <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
    end
  end

  // Next-state logic: enter BURST on a non-empty request, leave on last shift
  always_comb begin
    state_d = state_q;
    if (enb_i) begin
      case (state_q)
        ST_IDLE: begin
          if (w_burst_req && (w_amt_sat != '0)) begin
            state_d = ST_BURST;
          end
        end
        ST_BURST: begin
          if (cnt_q <= c_one) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath control: counter, done pulse and register update per state
  always_comb begin
    cnt_d     = cnt_q;
    done_d    = 1'b0;         // done lasts one edge even when enb is low
    w_op_mode = mode_i;
    shreg_d   = shreg_q;
    sout_d    = sout_q;
    if (enb_i) begin
      case (state_q)
        ST_IDLE: begin
          // BURST mode reaches the next-state block as a hold
          if (w_burst_req) begin
            if (w_amt_sat == '0) begin
              done_d = 1'b1;
            end else begin
              cnt_d = w_amt_sat;
            end
          end
          shreg_d = w_nxt_q;
          sout_d  = w_nxt_sout;
        end
        ST_BURST: begin
          w_op_mode = MODE_SHIFT;
          cnt_d     = cnt_q - c_one;
          if (cnt_q <= c_one) begin
            done_d = 1'b1;
          end
          shreg_d = w_nxt_q;
          sout_d  = w_nxt_sout;
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  assign q_o     = shreg_q;
  assign s_out_o = sout_q;
  assign busy_o  = (state_q == ST_BURST);
  assign done_o  = done_q;

endmodule : shift_reg_univ
`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_reg_univ
//  Description : Self-checking bench for shift_reg_univ (WIDTH=8) using a
//                behavioural reference model feeding an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_univ;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             enb;
  logic             dir;
  logic             s_in;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] amt;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             s_out;
  logic             busy;
  logic             done;

  shift_reg_univ #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .enb_i   (enb),
    .dir_i   (dir),
    .s_in_i  (s_in),
    .mode_i  (mode),
    .d_i     (d),
    .amt_i   (amt),
    .start_i (start),
    .q_o     (q),
    .s_out_o (s_out),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       so;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state
  logic [7:0] m_q;
  logic       m_so;
  logic       m_busy;
  logic       m_done;
  int         m_cnt;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 8'h00; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
  endtask

  // One rising edge of the behavioural model
  task automatic model_edge();
    int sat;
    logic nd;
    sat = (int'(amt) > 8) ? 8 : int'(amt);
    nd  = 1'b0;
    if (enb) begin
      if (!m_busy) begin
        case (mode)
          3'd0: begin
            m_so = dir ? m_q[0] : m_q[7];
            m_q  = dir ? ((m_q >> 1) | {s_in, 7'b0}) : ((m_q << 1) | {7'b0, s_in});
          end
          3'd1: begin
            m_so = dir ? m_q[0] : m_q[7];
            m_q  = dir ? ((m_q >> 1) | (m_q << 7)) : ((m_q << 1) | (m_q >> 7));
          end
          3'd2: begin m_q = d; m_so = 1'b0; end
          3'd4: begin
            m_so = dir ? m_q[0] : m_q[7];
            m_q  = dir ? 8'($signed(m_q) >>> 1) : (m_q << 1);
          end
          3'd5: begin
            if (start) begin
              if (sat == 0) nd = 1'b1;
              else begin m_cnt = sat; m_busy = 1'b1; end
            end
          end
          default: ;
        endcase
      end else begin
        m_so  = dir ? m_q[0] : m_q[7];
        m_q   = dir ? ((m_q >> 1) | {s_in, 7'b0}) : ((m_q << 1) | {7'b0, s_in});
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_busy = 1'b0; nd = 1'b1; end
      end
    end
    m_done = nd;
  endtask

  // Drive one cycle, push the model prediction, compare after the edge
  task automatic step(input logic e, input logic [2:0] md, input logic dr,
                      input logic si, input logic [7:0] dd,
                      input logic [CNT_W-1:0] am, input logic st);
    exp_t ex;
    exp_t got;
    enb = e; mode = md; dir = dr; s_in = si; d = dd; amt = am; start = st;
    model_edge();
    ex.q = m_q; ex.so = m_so; ex.busy = m_busy; ex.done = m_done;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check_val("q",     {24'd0, q},     {24'd0, got.q});
      check_val("s_out", {31'd0, s_out}, {31'd0, got.so});
      check_val("busy",  {31'd0, busy},  {31'd0, got.busy});
      check_val("done",  {31'd0, done},  {31'd0, got.done});
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_q"},    {24'd0, q},     32'h0);
    check_val({tag, "_sout"}, {31'd0, s_out}, 32'h0);
    check_val({tag, "_busy"}, {31'd0, busy},  32'h0);
    check_val({tag, "_done"}, {31'd0, done},  32'h0);
  endtask

  localparam logic [2:0] M_SH = 3'd0, M_RO = 3'd1, M_LD = 3'd2, M_HD = 3'd3,
                         M_AS = 3'd4, M_BU = 3'd5;

  initial begin
    reset = 1'b1; enb = 1'b0; dir = 1'b0; s_in = 1'b0; mode = M_HD;
    d = '0; amt = '0; start = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Load and enable freeze
    step(1, M_LD, 0, 0, 8'hA5, 0, 0);
    check_val("load_A5", {24'd0, q}, 32'hA5);
    step(0, M_SH, 0, 1, 8'h00, 0, 0);
    check_val("enb0_hold", {24'd0, q}, 32'hA5);

    // Logical shift left with fill 1
    step(1, M_SH, 0, 1, 8'h00, 0, 0);
    check_val("shl_4B", {24'd0, q}, 32'h4B);
    check_val("shl_so1", {31'd0, s_out}, 32'h1);
    step(1, M_SH, 0, 1, 8'h00, 0, 0);
    check_val("shl_97", {24'd0, q}, 32'h97);
    check_val("shl_so0", {31'd0, s_out}, 32'h0);

    // Rotate and arithmetic shifts
    step(1, M_LD, 0, 0, 8'h01, 0, 0);
    step(1, M_RO, 1, 0, 8'h00, 0, 0);
    check_val("rotr_80", {24'd0, q}, 32'h80);
    check_val("rotr_so", {31'd0, s_out}, 32'h1);
    step(1, M_AS, 1, 1, 8'h00, 0, 0);
    check_val("asr_C0", {24'd0, q}, 32'hC0);
    step(1, M_AS, 1, 1, 8'h00, 0, 0);
    check_val("asr_E0", {24'd0, q}, 32'hE0);
    step(1, M_LD, 0, 0, 8'h81, 0, 0);
    step(1, M_AS, 0, 1, 8'h00, 0, 0);
    check_val("asl_02", {24'd0, q}, 32'h02);
    check_val("asl_so", {31'd0, s_out}, 32'h1);
    step(1, 3'd6, 1, 1, 8'hFF, 0, 0);
    step(1, 3'd7, 0, 1, 8'hFF, 0, 0);
    check_val("mode7_hold", {24'd0, q}, 32'h02);

    // Burst of 3 right, zero fill
    step(1, M_LD, 0, 0, 8'hF0, 0, 0);
    step(1, M_BU, 1, 0, 8'h00, 3, 1);
    check_val("bst_busy", {31'd0, busy}, 32'h1);
    check_val("bst_q0", {24'd0, q}, 32'hF0);
    step(1, M_LD, 1, 0, 8'h55, 0, 0);
    check_val("bst_q1", {24'd0, q}, 32'h78);
    step(1, M_HD, 1, 0, 8'h55, 0, 1);
    check_val("bst_q2", {24'd0, q}, 32'h3C);
    step(1, M_HD, 1, 0, 8'h00, 0, 0);
    check_val("bst_q3", {24'd0, q}, 32'h1E);
    check_val("bst_done", {31'd0, done}, 32'h1);
    check_val("bst_nbusy", {31'd0, busy}, 32'h0);
    step(1, M_HD, 1, 0, 8'h00, 0, 0);
    check_val("bst_done_clr", {31'd0, done}, 32'h0);

    // Same burst with two stalled cycles mid-way
    step(1, M_LD, 0, 0, 8'hF0, 0, 0);
    step(1, M_BU, 1, 0, 8'h00, 3, 1);
    step(1, M_HD, 1, 0, 8'h00, 0, 0);
    step(0, M_HD, 1, 1, 8'h00, 0, 0);
    step(0, M_HD, 1, 1, 8'h00, 0, 0);
    check_val("stall_busy", {31'd0, busy}, 32'h1);
    step(1, M_HD, 1, 0, 8'h00, 0, 0);
    step(1, M_HD, 1, 0, 8'h00, 0, 0);
    check_val("stall_q", {24'd0, q}, 32'h1E);
    check_val("stall_done", {31'd0, done}, 32'h1);
    step(0, M_HD, 1, 0, 8'h00, 0, 0);
    check_val("done_clr_enb0", {31'd0, done}, 32'h0);

    // Zero-length burst
    step(1, M_BU, 0, 1, 8'h00, 0, 1);
    check_val("amt0_done", {31'd0, done}, 32'h1);
    check_val("amt0_busy", {31'd0, busy}, 32'h0);
    check_val("amt0_q", {24'd0, q}, 32'h1E);
    step(1, M_HD, 0, 1, 8'h00, 0, 0);

    // Saturating burst length
    step(1, M_LD, 0, 0, 8'hFF, 0, 0);
    step(1, M_BU, 1, 0, 8'h00, 15, 1);
    for (int i = 0; i < 8; i++) step(1, M_HD, 1, 0, 8'h00, 0, 0);
    check_val("sat_q", {24'd0, q}, 32'h00);
    check_val("sat_done", {31'd0, done}, 32'h1);

    // Back-to-back bursts with start held high
    step(1, M_LD, 0, 0, 8'h0F, 0, 0);
    for (int i = 0; i < 8; i++) step(1, M_BU, 0, 1, 8'h00, 2, 1);

    // Reset after the second burst shift
    step(1, M_LD, 0, 0, 8'hAA, 0, 0);
    step(1, M_BU, 0, 1, 8'h00, 3, 1);
    step(1, M_HD, 0, 1, 8'h00, 0, 0);
    step(1, M_HD, 0, 1, 8'h00, 0, 0);
    #2 reset = 1'b1;
    #1 check_zero("midrst");
    model_reset();
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1, M_HD, 0, 0, 8'h00, 0, 0);
    check_val("midrst_nodone", {31'd0, done}, 32'h0);

    // Randomised sequences against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
           1'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_shift_reg_univ
`default_nettype wire
